// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: data width, default bit
// pacing and the state encodings of the receive and handshake machines.
package uart_pkg;

    localparam int DATA_BITS             = 8;
    localparam int CLKS_PER_BIT_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_WAIT = 2'd2
    } hs_state_t;

endpackage

// File: rtl/uart_rcv_if.sv
// Consumer-side bundle of the UART receiver: received byte, 4-phase Req/Ack
// handshake and the two error pulses. The receiver is the master.
interface uart_rcv_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] char;
    logic                 Req;
    logic                 Ack;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output char,
        output Req,
        output frame_err,
        output overrun,
        input  Ack
    );

    modport slave (
        input  char,
        input  Req,
        input  frame_err,
        input  overrun,
        output Ack
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// 1 so an idle-high serial line does not look like a start edge after reset.
module uart_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at its
// mid-point, and offers completed bytes to a consumer over a 4-phase Req/Ack
// handshake that runs independently of reception. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          TxD,
    uart_rcv_if.master    bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            r_rx_state;
    hs_state_t            r_hs_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_char;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_rx_s;
    logic w_bit_end;
    logic w_half_end;
    logic w_hs_busy;
    logic w_load;

    uart_sync u_sync (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_async (TxD),
        .o_sync  (w_rx_s)
    );

    assign w_bit_end  = (r_cnt == BIT_LAST);
    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_hs_busy  = (r_hs_state != HS_IDLE);
    assign w_load     = (r_rx_state == STOP) && w_bit_end && w_rx_s && !w_hs_busy;

    // Receive sequencing: start-edge hunt, mid-bit sampling, stop-bit check.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rx_state  <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_rx_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt      <= '0;
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_bit_idx  <= '0;
                            r_rx_state <= DATA;
                        end else begin
                            r_rx_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt              <= '0;
                        r_shreg[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == IDX_LAST) begin
                            r_rx_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_overrun  <= w_hs_busy;
                            r_rx_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= BREAK_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (w_rx_s) begin
                        r_rx_state <= IDLE;
                    end
                end
                default: begin
                    r_rx_state <= IDLE;
                end
            endcase
        end
    end

    // Output byte register: only updated when the consumer is free to take it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_char <= '0;
        end else if (w_load) begin
            r_char <= r_shreg;
        end
    end

    // 4-phase handshake toward the consumer, independent of reception.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_hs_state <= HS_IDLE;
        end else begin
            case (r_hs_state)
                HS_IDLE: begin
                    if (w_load) begin
                        r_hs_state <= HS_REQ;
                    end
                end
                HS_REQ: begin
                    if (bus.Ack) begin
                        r_hs_state <= HS_WAIT;
                    end
                end
                HS_WAIT: begin
                    if (!bus.Ack) begin
                        r_hs_state <= HS_IDLE;
                    end
                end
                default: begin
                    r_hs_state <= HS_IDLE;
                end
            endcase
        end
    end

    assign bus.char      = r_char;
    assign bus.Req       = (r_hs_state == HS_REQ);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed and randomized bench for uart_rcv. Frames are built bit by bit on
// TxD; a consumer process answers the handshake with a configurable delay;
// a monitor collects delivered bytes and error pulses for comparison against
// the bytes and error counts the bench itself predicts from framing rules.
module tb_uart_rcv;
    import uart_pkg::*;

    localparam int CPB     = 8;
    localparam int HB      = CPB / 2;
    // Edges from driving the start bit (just after an edge) to Req seen high:
    // 1 edge to capture, 2 synchronizer edges incl. IDLE detect, HB to the
    // start-bit check, 9 bit periods to the stop sample.
    localparam int LATENCY = 3 + HB + 9 * CPB;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic TxD   = 1'b1;

    uart_rcv_if bus ();

    uart_rcv #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HB)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .TxD   (TxD),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         cycle       = 0;
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    int         frameErrCnt = 0;
    int         overrunCnt  = 0;
    int         expFrameErr = 0;
    int         expOverrun  = 0;
    int         lastReqRise = 0;
    int         ackSeenCycle = -1;
    int         txStartCycle = 0;
    logic       ackHold  = 1'b0;
    int         ackDelay = 0;
    int         reqWait  = 0;
    logic       prevReq  = 1'b0;
    logic [7:0] prevChar = 8'h00;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold TxD at a level for a number of clock cycles.
    task automatic drive(input logic lvl, input int n);
        TxD = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one 8N1 frame, LSB first, with a chosen stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        txStartCycle = cycle;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            drive(data[i], CPB);
        end
        drive(stopBit, CPB);
    endtask

    // Compare collected bytes and error counts with predictions, then reset.
    task automatic checkScoreboard(input string tag);
        int n;
        checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_byte"}, gotQ[i], expQ[i]);
        end
        checkOutput({tag, "_frameErr"}, frameErrCnt, expFrameErr);
        checkOutput({tag, "_overrun"}, overrunCnt, expOverrun);
        gotQ.delete();
        expQ.delete();
        frameErrCnt = 0;
        overrunCnt  = 0;
        expFrameErr = 0;
        expOverrun  = 0;
    endtask

    // Consumer: raises Ack ackDelay cycles after Req, drops it once Req falls.
    initial begin
        bus.Ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ackHold) begin
                bus.Ack = 1'b0;
            end else if (bus.Req && !bus.Ack) begin
                if (reqWait >= ackDelay) bus.Ack = 1'b1;
                else reqWait++;
            end else if (!bus.Req && bus.Ack) begin
                bus.Ack = 1'b0;
            end
            if (!bus.Req) reqWait = 0;
        end
    end

    // Monitor: records bytes at each Req rise, counts error pulses and checks
    // handshake/stability properties while out of reset.
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #2;
            if (clr_n) begin
                if (bus.frame_err) frameErrCnt++;
                if (bus.overrun) overrunCnt++;
                if (bus.frame_err || bus.overrun) begin
                    checkOutput("errExclusive", {31'd0, bus.frame_err & bus.overrun}, 32'd0);
                end
                if (bus.Req && !prevReq) begin
                    gotQ.push_back(bus.char);
                    lastReqRise  = cycle;
                    ackSeenCycle = -1;
                end
                if (bus.Req && prevReq) begin
                    checkOutput("charStable", bus.char, prevChar);
                end
                if (!bus.Req && prevReq) begin
                    checkOutput("reqFallAfterAck", cycle - ackSeenCycle, 32'd1);
                end
                if (bus.Req && bus.Ack && ackSeenCycle < 0) begin
                    ackSeenCycle = cycle;
                end
            end
            prevReq  = bus.Req;
            prevChar = bus.char;
        end
    end

    // Hard time bound so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized frame burst.
    initial begin
        logic [7:0] data;
        logic       bad;
        int         gap;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetChar", bus.char, 32'h00);
        checkOutput("resetReq", {31'd0, bus.Req}, 32'd0);
        checkOutput("resetFrameErr", {31'd0, bus.frame_err}, 32'd0);
        checkOutput("resetOverrun", {31'd0, bus.overrun}, 32'd0);
        clr_n = 1'b1;
        drive(1'b1, 2 * CPB);

        // Single frame, immediate Ack.
        ackDelay = 0;
        applyStimulus(8'hA5, 1'b1);
        expQ.push_back(8'hA5);
        drive(1'b1, 2 * CPB);
        checkOutput("a5Latency", lastReqRise - txStartCycle, LATENCY);
        checkOutput("a5Char", bus.char, 32'hA5);
        checkOutput("a5ReqIdle", {31'd0, bus.Req}, 32'd0);
        checkScoreboard("a5");

        // Short low glitch on an idle line must be ignored.
        drive(1'b0, 3);
        drive(1'b1, 12 * CPB);
        checkScoreboard("glitch");

        // Bad stop bit followed by a break, then a good frame.
        applyStimulus(8'h3C, 1'b0);
        drive(1'b0, 40);
        checkOutput("breakReq", {31'd0, bus.Req}, 32'd0);
        expFrameErr = 1;
        drive(1'b1, 2 * CPB);
        applyStimulus(8'h81, 1'b1);
        expQ.push_back(8'h81);
        drive(1'b1, 2 * CPB);
        checkScoreboard("break");

        // Consumer stalls: second byte is dropped as an overrun.
        ackHold = 1'b1;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        drive(1'b1, CPB);
        checkOutput("ovrReq", {31'd0, bus.Req}, 32'd1);
        checkOutput("ovrChar", bus.char, 32'h11);
        expQ.push_back(8'h11);
        expOverrun = 1;
        ackHold = 1'b0;
        drive(1'b1, 2 * CPB);
        checkOutput("ovrReleased", {31'd0, bus.Req}, 32'd0);
        checkScoreboard("overrun");

        // Reset in the middle of data bit 4 of 0xFF, then a clean frame.
        drive(1'b0, CPB);
        drive(1'b1, 4 * CPB + HB);
        clr_n = 1'b0;
        #2;
        checkOutput("midResetChar", bus.char, 32'h00);
        checkOutput("midResetReq", {31'd0, bus.Req}, 32'd0);
        checkOutput("midResetFrameErr", {31'd0, bus.frame_err}, 32'd0);
        checkOutput("midResetOverrun", {31'd0, bus.overrun}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        clr_n = 1'b1;
        drive(1'b1, 6 * CPB);
        applyStimulus(8'h5A, 1'b1);
        expQ.push_back(8'h5A);
        drive(1'b1, 2 * CPB);
        checkScoreboard("reset");

        // Back-to-back frames with a slow consumer.
        ackDelay = 3;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h55, 1'b1);
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h55);
        drive(1'b1, 2 * CPB);
        checkScoreboard("b2b");

        // Random bytes, random gaps, occasional bad stop bits.
        for (int k = 0; k < 16; k++) begin
            data     = 8'($urandom);
            bad      = ($urandom_range(0, 3) == 0);
            gap      = $urandom_range(0, 2 * CPB);
            ackDelay = $urandom_range(0, 4);
            applyStimulus(data, !bad);
            if (bad) begin
                expFrameErr++;
                drive(1'b1, CPB + gap);
            end else begin
                expQ.push_back(data);
                drive(1'b1, gap);
            end
        end
        drive(1'b1, 2 * CPB);
        checkScoreboard("random");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
